// File: rtl/btfly_r2_pipe.sv
// rtl/btfly_r2_pipe.sv - pipelined radix-2 DIT butterfly with rounded, saturating twiddle multiply
module btfly_r2_pipe #(
    parameter int NB_INPUT  = 8,
    parameter int NB_TW     = 8,
    parameter int NB_OUTPUT = 9
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    input  logic                        i_valid,
    input  logic signed [NB_INPUT-1:0]  i_data0_r,
    input  logic signed [NB_INPUT-1:0]  i_data0_i,
    input  logic signed [NB_INPUT-1:0]  i_data1_r,
    input  logic signed [NB_INPUT-1:0]  i_data1_i,
    input  logic signed [NB_TW-1:0]     i_tw_r,
    input  logic signed [NB_TW-1:0]     i_tw_i,
    input  logic                        i_tw_bypass,
    input  logic                        i_scale,
    input  logic                        i_ovf_clr,
    output logic                        o_valid,
    output logic signed [NB_OUTPUT-1:0] o_data0_r,
    output logic signed [NB_OUTPUT-1:0] o_data0_i,
    output logic signed [NB_OUTPUT-1:0] o_data1_r,
    output logic signed [NB_OUTPUT-1:0] o_data1_i,
    output logic                        o_ovf
);

    localparam int NB_PROD = NB_INPUT + NB_TW + 1;
    localparam logic signed [NB_PROD-1:0] RND_HALF = NB_PROD'(1) << (NB_TW - 2);
    localparam logic signed [NB_PROD-1:0] SAT_MAX  = (NB_PROD'(1) << (NB_INPUT - 1)) - NB_PROD'(1);
    localparam logic signed [NB_PROD-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic signed [NB_OUTPUT-1:0] ONE_O  = NB_OUTPUT'(1);

    // S1: captured operands and per-sample mode bits
    logic signed [NB_INPUT-1:0] s1_x0r_q, s1_x0r_d, s1_x0i_q, s1_x0i_d;
    logic signed [NB_INPUT-1:0] s1_x1r_q, s1_x1r_d, s1_x1i_q, s1_x1i_d;
    logic signed [NB_TW-1:0]    s1_twr_q, s1_twr_d, s1_twi_q, s1_twi_d;
    logic                       s1_byp_q, s1_byp_d, s1_scale_q, s1_scale_d;
    logic                       s1_valid_q, s1_valid_d;

    logic signed [NB_INPUT-1:0] s2_x0r_q, s2_x0r_d, s2_x0i_q, s2_x0i_d;
    logic signed [NB_INPUT-1:0] s2_tr_q, s2_tr_d, s2_ti_q, s2_ti_d;
    logic                       s2_scale_q, s2_scale_d, s2_valid_q, s2_valid_d;

    logic signed [NB_OUTPUT-1:0] y0r_q, y0r_d, y0i_q, y0i_d, y1r_q, y1r_d, y1i_q, y1i_d;
    logic                        o_valid_q, o_valid_d;
    logic                        ovf_q, ovf_d;

    logic signed [NB_PROD-1:0]   x1r_e, x1i_e, twr_e, twi_e;
    logic signed [NB_PROD-1:0]   pr_full, pi_full, pr_rnd, pi_rnd;
    logic signed [NB_INPUT-1:0]  tr_w, ti_w;
    logic                        sat_r, sat_i;
    logic signed [NB_OUTPUT-1:0] x0r_e, x0i_e, tr_e, ti_e;

    function automatic logic signed [NB_OUTPUT-1:0] halve(input logic signed [NB_OUTPUT-1:0] v,
                                                          input logic en);
        return en ? ((v + ONE_O) >>> 1) : v;
    endfunction

    always_comb begin
        x1r_e   = NB_PROD'(s1_x1r_q);
        x1i_e   = NB_PROD'(s1_x1i_q);
        twr_e   = NB_PROD'(s1_twr_q);
        twi_e   = NB_PROD'(s1_twi_q);
        pr_full = x1r_e * twr_e - x1i_e * twi_e;
        pi_full = x1r_e * twi_e + x1i_e * twr_e;
        pr_rnd  = (pr_full + RND_HALF) >>> (NB_TW - 1);
        pi_rnd  = (pi_full + RND_HALF) >>> (NB_TW - 1);

        sat_r = 1'b0;
        tr_w  = pr_rnd[NB_INPUT-1:0];
        if (pr_rnd > SAT_MAX) begin
            tr_w  = SAT_MAX[NB_INPUT-1:0];
            sat_r = 1'b1;
        end else if (pr_rnd < SAT_MIN) begin
            tr_w  = SAT_MIN[NB_INPUT-1:0];
            sat_r = 1'b1;
        end

        sat_i = 1'b0;
        ti_w  = pi_rnd[NB_INPUT-1:0];
        if (pi_rnd > SAT_MAX) begin
            ti_w  = SAT_MAX[NB_INPUT-1:0];
            sat_i = 1'b1;
        end else if (pi_rnd < SAT_MIN) begin
            ti_w  = SAT_MIN[NB_INPUT-1:0];
            sat_i = 1'b1;
        end

        // Bypass passes x1 through untouched, so it can never flag saturation
        if (s1_byp_q) begin
            tr_w  = s1_x1r_q;
            ti_w  = s1_x1i_q;
            sat_r = 1'b0;
            sat_i = 1'b0;
        end
    end

    always_comb begin
        x0r_e = NB_OUTPUT'(s2_x0r_q);
        x0i_e = NB_OUTPUT'(s2_x0i_q);
        tr_e  = NB_OUTPUT'(s2_tr_q);
        ti_e  = NB_OUTPUT'(s2_ti_q);

        s1_x0r_d   = s1_x0r_q;
        s1_x0i_d   = s1_x0i_q;
        s1_x1r_d   = s1_x1r_q;
        s1_x1i_d   = s1_x1i_q;
        s1_twr_d   = s1_twr_q;
        s1_twi_d   = s1_twi_q;
        s1_byp_d   = s1_byp_q;
        s1_scale_d = s1_scale_q;
        s1_valid_d = s1_valid_q;
        s2_x0r_d   = s2_x0r_q;
        s2_x0i_d   = s2_x0i_q;
        s2_tr_d    = s2_tr_q;
        s2_ti_d    = s2_ti_q;
        s2_scale_d = s2_scale_q;
        s2_valid_d = s2_valid_q;
        y0r_d      = y0r_q;
        y0i_d      = y0i_q;
        y1r_d      = y1r_q;
        y1i_d      = y1i_q;
        o_valid_d  = o_valid_q;

        if (i_enable) begin
            s1_x0r_d   = i_data0_r;
            s1_x0i_d   = i_data0_i;
            s1_x1r_d   = i_data1_r;
            s1_x1i_d   = i_data1_i;
            s1_twr_d   = i_tw_r;
            s1_twi_d   = i_tw_i;
            s1_byp_d   = i_tw_bypass;
            s1_scale_d = i_scale;
            s1_valid_d = i_valid;

            s2_x0r_d   = s1_x0r_q;
            s2_x0i_d   = s1_x0i_q;
            s2_tr_d    = tr_w;
            s2_ti_d    = ti_w;
            s2_scale_d = s1_scale_q;
            s2_valid_d = s1_valid_q;

            o_valid_d  = s2_valid_q;
            // Output data only tracks valid samples so it holds the last good result
            if (s2_valid_q) begin
                y0r_d = halve(x0r_e + tr_e, s2_scale_q);
                y0i_d = halve(x0i_e + ti_e, s2_scale_q);
                y1r_d = halve(x0r_e - tr_e, s2_scale_q);
                y1i_d = halve(x0i_e - ti_e, s2_scale_q);
            end
        end

        ovf_d = ovf_q;
        if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (i_enable && s1_valid_q && (sat_r || sat_i)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_x0r_q   <= '0;
            s1_x0i_q   <= '0;
            s1_x1r_q   <= '0;
            s1_x1i_q   <= '0;
            s1_twr_q   <= '0;
            s1_twi_q   <= '0;
            s1_byp_q   <= 1'b0;
            s1_scale_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_x0r_q   <= '0;
            s2_x0i_q   <= '0;
            s2_tr_q    <= '0;
            s2_ti_q    <= '0;
            s2_scale_q <= 1'b0;
            s2_valid_q <= 1'b0;
            y0r_q      <= '0;
            y0i_q      <= '0;
            y1r_q      <= '0;
            y1i_q      <= '0;
            o_valid_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_x0r_q   <= s1_x0r_d;
            s1_x0i_q   <= s1_x0i_d;
            s1_x1r_q   <= s1_x1r_d;
            s1_x1i_q   <= s1_x1i_d;
            s1_twr_q   <= s1_twr_d;
            s1_twi_q   <= s1_twi_d;
            s1_byp_q   <= s1_byp_d;
            s1_scale_q <= s1_scale_d;
            s1_valid_q <= s1_valid_d;
            s2_x0r_q   <= s2_x0r_d;
            s2_x0i_q   <= s2_x0i_d;
            s2_tr_q    <= s2_tr_d;
            s2_ti_q    <= s2_ti_d;
            s2_scale_q <= s2_scale_d;
            s2_valid_q <= s2_valid_d;
            y0r_q      <= y0r_d;
            y0i_q      <= y0i_d;
            y1r_q      <= y1r_d;
            y1i_q      <= y1i_d;
            o_valid_q  <= o_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_valid   = o_valid_q;
    assign o_data0_r = y0r_q;
    assign o_data0_i = y0i_q;
    assign o_data1_r = y1r_q;
    assign o_data1_i = y1i_q;
    assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_btfly_r2_pipe.sv
// tb/tb_btfly_r2_pipe.sv - self-checking bench for btfly_r2_pipe
module tb_btfly_r2_pipe;

    localparam int NI = 8;
    localparam int NT = 8;
    localparam int NO = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 i_rst_n, i_enable, i_valid, i_tw_bypass, i_scale, i_ovf_clr;
    logic signed [NI-1:0] i_data0_r, i_data0_i, i_data1_r, i_data1_i;
    logic signed [NT-1:0] i_tw_r, i_tw_i;
    logic                 o_valid, o_ovf;
    logic signed [NO-1:0] o_data0_r, o_data0_i, o_data1_r, o_data1_i;

    btfly_r2_pipe #(.NB_INPUT(NI), .NB_TW(NT), .NB_OUTPUT(NO)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_valid(i_valid),
        .i_data0_r(i_data0_r), .i_data0_i(i_data0_i),
        .i_data1_r(i_data1_r), .i_data1_i(i_data1_i),
        .i_tw_r(i_tw_r), .i_tw_i(i_tw_i), .i_tw_bypass(i_tw_bypass),
        .i_scale(i_scale), .i_ovf_clr(i_ovf_clr), .o_valid(o_valid),
        .o_data0_r(o_data0_r), .o_data0_i(o_data0_i),
        .o_data1_r(o_data1_r), .o_data1_i(o_data1_i), .o_ovf(o_ovf)
    );

    typedef struct {
        int x0r, x0i, x1r, x1i, wr, wi;
        bit byp, scl;
    } sample_t;

    typedef struct {
        int y0r, y0i, y1r, y1i;
        bit sat;
    } res_t;

    typedef struct {
        sample_t s;
        res_t    r;
        bit      eovf;
    } vec_t;

    typedef struct {
        res_t r;
        int   due;
    } pend_t;

    int      n_checks = 0;
    int      n_fail   = 0;
    int      ecnt     = 0;
    pend_t   sbq[$];
    bit      m_valid  = 1'b0;
    bit      m_ovf    = 1'b0;
    res_t    m_res;
    sample_t cur;
    vec_t    vecs[8];

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int floor_div(input int num, input int den);
        if (num >= 0) return num / den;
        return -((-num + den - 1) / den);
    endfunction

    function automatic int clamp(input int v, output bit hit);
        int hi = 2 ** (NI - 1) - 1;
        int lo = -(2 ** (NI - 1));
        hit = (v > hi) || (v < lo);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference butterfly computed with plain integer arithmetic
    function automatic res_t model(input sample_t s);
        res_t r;
        int   tr, ti;
        bit   hr, hi;
        if (s.byp) begin
            tr = s.x1r;
            ti = s.x1i;
            r.sat = 1'b0;
        end else begin
            tr = clamp(floor_div(s.x1r * s.wr - s.x1i * s.wi + 2 ** (NT - 2), 2 ** (NT - 1)), hr);
            ti = clamp(floor_div(s.x1r * s.wi + s.x1i * s.wr + 2 ** (NT - 2), 2 ** (NT - 1)), hi);
            r.sat = hr || hi;
        end
        r.y0r = s.x0r + tr;
        r.y0i = s.x0i + ti;
        r.y1r = s.x0r - tr;
        r.y1i = s.x0i - ti;
        if (s.scl) begin
            r.y0r = floor_div(r.y0r + 1, 2);
            r.y0i = floor_div(r.y0i + 1, 2);
            r.y1r = floor_div(r.y1r + 1, 2);
            r.y1i = floor_div(r.y1i + 1, 2);
        end
        return r;
    endfunction

    function automatic logic [4*NO-1:0] pack_res(input res_t r);
        return {NO'(r.y0r), NO'(r.y0i), NO'(r.y1r), NO'(r.y1i)};
    endfunction

    function automatic logic [4*NO-1:0] pack_out();
        return {o_data0_r, o_data0_i, o_data1_r, o_data1_i};
    endfunction

    function automatic vec_t mk(input int x0r, x0i, x1r, x1i, wr, wi, input bit byp, scl,
                                input int y0r, y0i, y1r, y1i, input bit eovf);
        vec_t v;
        v.s.x0r = x0r; v.s.x0i = x0i; v.s.x1r = x1r; v.s.x1i = x1i;
        v.s.wr = wr; v.s.wi = wi; v.s.byp = byp; v.s.scl = scl;
        v.r.y0r = y0r; v.r.y0i = y0i; v.r.y1r = y1r; v.r.y1i = y1i;
        v.r.sat = eovf;
        v.eovf = eovf;
        return v;
    endfunction

    function automatic sample_t rand_sample();
        sample_t s;
        s.x0r = int'($urandom_range(0, 255)) - 128;
        s.x0i = int'($urandom_range(0, 255)) - 128;
        s.x1r = int'($urandom_range(0, 255)) - 128;
        s.x1i = int'($urandom_range(0, 255)) - 128;
        s.wr  = int'($urandom_range(0, 255)) - 128;
        s.wi  = int'($urandom_range(0, 255)) - 128;
        s.byp = ($urandom_range(0, 3) == 0);
        s.scl = 1'($urandom_range(0, 1));
        return s;
    endfunction

    task automatic drive(input sample_t s, input bit v);
        cur         = s;
        i_valid     = v;
        i_data0_r   = NI'(s.x0r);
        i_data0_i   = NI'(s.x0i);
        i_data1_r   = NI'(s.x1r);
        i_data1_i   = NI'(s.x1i);
        i_tw_r      = NT'(s.wr);
        i_tw_i      = NT'(s.wi);
        i_tw_bypass = s.byp;
        i_scale     = s.scl;
    endtask

    // One clock: update the timing model at the edge, compare outputs 1ns later
    task automatic tick();
        bit      en, v, clr, rst, set_ovf;
        sample_t s;
        pend_t   p;
        @(posedge clk);
        en = i_enable; v = i_valid; clr = i_ovf_clr; rst = i_rst_n; s = cur;
        if (!rst) begin
            sbq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_res   = '{default: 0};
        end else begin
            set_ovf = 1'b0;
            if (en) begin
                ecnt++;
                foreach (sbq[k]) if (sbq[k].due == ecnt + 1 && sbq[k].r.sat) set_ovf = 1'b1;
                m_valid = 1'b0;
                if (sbq.size() > 0 && sbq[0].due == ecnt) begin
                    m_valid = 1'b1;
                    p = sbq.pop_front();
                    m_res = p.r;
                end
                if (v) begin
                    p.r   = model(s);
                    p.due = ecnt + 2;
                    sbq.push_back(p);
                end
            end
            if (set_ovf) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        #1;
        chk("model_o_valid", o_valid, m_valid);
        chk("model_o_data", pack_out(), pack_res(m_res));
        chk("model_o_ovf", o_ovf, m_ovf);
    endtask

    task automatic apply_vec(input int idx);
        i_enable  = 1'b1;
        i_ovf_clr = 1'b0;
        drive(vecs[idx].s, 1'b1);
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        chk($sformatf("vec%0d_valid", idx), o_valid, 1);
        chk($sformatf("vec%0d_data", idx), pack_out(), pack_res(vecs[idx].r));
        chk($sformatf("vec%0d_ovf", idx), o_ovf, vecs[idx].eovf);
        tick();
        chk($sformatf("vec%0d_one_cycle", idx), o_valid, 0);
    endtask

    initial begin
        vecs[0] = mk(10, -4, 20, 6, 0, 0, 1, 0, 30, 2, -10, -10, 0);
        vecs[1] = mk(10, -4, 20, 6, -128, 0, 0, 0, -10, -10, 30, 2, 0);
        vecs[2] = mk(0, 0, 1, 0, 64, 0, 0, 0, 1, 0, -1, 0, 0);
        vecs[3] = mk(3, 0, 2, 0, 0, 0, 1, 1, 3, 0, 1, 0, 0);
        vecs[4] = mk(-3, 0, 0, 0, 0, 0, 1, 1, -1, 0, -1, 0, 0);
        vecs[5] = mk(5, 5, 10, 20, 0, 127, 0, 0, -15, 15, 25, -5, 0);
        vecs[6] = mk(127, -128, 127, -128, 127, 0, 0, 1, 127, -127, 1, 0, 0);
        vecs[7] = mk(0, 0, -128, 0, -128, 0, 0, 0, 127, 0, -127, 0, 1);

        m_res = '{default: 0};
        cur   = '{default: 0};
        i_rst_n   = 1'b1;
        i_enable  = 1'b1;
        i_ovf_clr = 1'b0;
        drive(cur, 1'b0);
        #1 i_rst_n = 1'b0;
        #1;
        chk("reset_valid", o_valid, 0);
        chk("reset_data", pack_out(), 0);
        chk("reset_ovf", o_ovf, 0);
        tick();
        tick();
        i_rst_n = 1'b1;

        for (int i = 0; i < 8; i++) apply_vec(i);

        i_ovf_clr = 1'b1;
        tick();
        i_ovf_clr = 1'b0;
        chk("ovf_clear", o_ovf, 0);

        drive(vecs[7].s, 1'b1);
        i_ovf_clr = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_ovf_clr = 1'b0;
        chk("ovf_set_wins", o_ovf, 1);
        tick();

        i_enable  = 1'b0;
        i_ovf_clr = 1'b1;
        tick();
        chk("ovf_clear_stalled", o_ovf, 0);
        i_enable  = 1'b1;
        i_ovf_clr = 1'b0;
        tick();

        for (int c = 0; c < 8; c++) begin
            i_enable = !(c == 3 || c == 4);
            drive(rand_sample(), 1'b1);
            tick();
        end
        i_enable = 1'b1;
        i_valid  = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("stall_stream_drained", sbq.size(), 0);

        for (int c = 0; c < 200; c++) begin
            i_enable  = ($urandom_range(0, 3) != 0);
            i_ovf_clr = ($urandom_range(0, 15) == 0);
            drive(rand_sample(), 1'($urandom_range(0, 1)));
            tick();
        end
        i_enable  = 1'b1;
        i_ovf_clr = 1'b0;
        i_valid   = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("random_drained", sbq.size(), 0);

        drive(vecs[7].s, 1'b1);
        tick();
        drive(rand_sample(), 1'b1);
        tick();
        i_valid = 1'b0;
        #3 i_rst_n = 1'b0;
        #1;
        chk("async_reset_valid", o_valid, 0);
        chk("async_reset_data", pack_out(), 0);
        chk("async_reset_ovf", o_ovf, 0);
        tick();
        i_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        apply_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btfly_r2_pipe.md
Name: btfly_r2_pipe

Overview:
- Pipelined, parametrised radix-2 DIT butterfly for the FFT datapath.
- Computes y0 = x0 + W·x1 and y1 = x0 − W·x1, where x0/x1 are complex samples and W is a complex twiddle.
- Adds the following:
  - a rounded, saturating twiddle multiply;
  - a runtime divide-by-2 scaling mode;
  - a twiddle bypass;
  - a valid/enable pipeline;
  - a sticky overflow flag.
- Sits between the stage reorder memory and the next FFT stage.

Parameters:
- NB_INPUT, 8, signed width of each input real/imag component.
- NB_TW, 8, signed twiddle component width. Format is Q1.(NB_TW−1), so −2^(NB_TW−1) = −1.0.
- NB_OUTPUT, 9, output component width. Must be ≥ NB_INPUT+1; results are sign-extended up to NB_OUTPUT.

Ports:
- clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  global pipeline advance. When 0, every register holds.
- i_valid  in  1  input sample pair valid.
- i_data0_r / i_data0_i  in  NB_INPUT  x0 real/imag, signed.
- i_data1_r / i_data1_i  in  NB_INPUT  x1 real/imag, signed.
- i_tw_r / i_tw_i  in  NB_TW  twiddle real/imag, signed.
- i_tw_bypass  in  1  1 = treat W as exactly 1+0j.
- i_scale  in  1  1 = halve butterfly outputs with rounding.
- i_ovf_clr  in  1  synchronous clear of o_ovf.
- o_valid  out  1  output valid.
- o_data0_r / o_data0_i  out  NB_OUTPUT  y0, signed.
- o_data1_r / o_data1_i  out  NB_OUTPUT  y1, signed.
- o_ovf  out  1  sticky twiddle-saturation flag.

Behaviour:
- Reset (i_rst_n=0, asynchronous): all pipeline registers, o_valid, all o_data*, and o_ovf go to 0 immediately. Deassertion is synchronous to clk. Reset mid-operation discards all in-flight samples.
- Pipeline: 3 register stages. Latency is 3 enabled clock edges from input to output.
  - The i_valid shift register advances only when i_enable=1.
  - i_tw_bypass and i_scale are captured with the sample in S1 and travel with it, so a mode change affects only later samples.
  - Invalid samples still flow through the pipeline. Only o_valid marks usable data.
- S1: register x0, x1, W and the mode bits.
- S2, twiddle product t = W·x1:
  - pr = x1r·wr − x1i·wi and pi = x1r·wi + x1i·wr, each at full width NB_INPUT+NB_TW+1.
  - Round half-up: add 2^(NB_TW−2), then arithmetic right-shift by NB_TW−1.
  - Saturate to NB_INPUT bits, to the range [−2^(NB_INPUT−1), 2^(NB_INPUT−1)−1].
  - Bypass: t = x1 exactly, with no rounding and no saturation.
  - Register t and the delayed x0.
- S3, butterfly:
  - s = sx(x0)+sx(t) and d = sx(x0)−sx(t), computed at NB_INPUT+1 bits. This cannot overflow.
  - i_scale=1: out = (v + 1) >>> 1, arithmetic shift, so halves round up (−3 → −1).
  - Sign-extend the result to NB_OUTPUT and register it. o_data* hold their value while o_valid=0 or i_enable=0.
- o_ovf:
  - Set on an enabled edge where a valid sample in S2 saturated either component.
  - Cleared by i_ovf_clr=1 on a rising edge.
  - If a set and a clear occur on the same edge, set wins.
  - i_ovf_clr is honoured even when i_enable=0.
- Stall: when i_enable=0, o_valid and o_data* hold. Inputs presented during a stall are ignored.
- Simultaneous i_valid with i_enable=0: the sample is dropped. The upstream block owns retry.

Test Plan:
- Bypass, scale=0:
  - Stimulus: x0=(10,−4), x1=(20,6), i_valid for 1 cycle.
  - Required: after 3 edges, o_valid=1 for 1 cycle, y0=(30,2), y1=(−10,−10).
- W=(−128,0) (−1.0), no bypass, with x0=(10,−4), x1=(20,6):
  - Required: t=(−20,−6), y0=(−10,−10), y1=(30,2), o_ovf stays 0.
- Overflow:
  - Stimulus: x1=(−128,0), W=(−128,0).
  - Required: t_r saturates to 127, o_ovf=1 and stays 1. i_ovf_clr pulse → o_ovf=0 next edge. Set and clear on the same edge → o_ovf=1.
- Rounding:
  - x1=(1,0), W=(64,0) → t=(1,0).
  - Bypass with scale=1: x0=(3,0), x1=(2,0) → y0_r=3, y1_r=1.
  - x0=(−3,0), x1=(0,0) → y0_r=−1, y1_r=−1.
- Stall and stream:
  - Stimulus: a stream of 6 valid samples with i_enable low for 2 cycles mid-stream.
  - Required: outputs match the reference model in order, no duplicate or lost o_valid, outputs held during the stall.
- Reset:
  - Stimulus: assert i_rst_n=0 asynchronously with 2 samples in flight.
  - Required: all outputs 0 immediately, and no o_valid after release until a new sample has had 3 enabled edges.
